// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: waits for a stable PLL lock, then walks the sensor through
// XCLK start, PWDN release, reset release and settle. Optional lock-loss counter: CAM_PWR_SEQ_LOSS_CNT_EN.
module cam_pwr_seq #(
  parameter int LOCK_STABLE_CYC = 1024,
  parameter int PWDN_CYC        = 126000,
  parameter int RST_CYC         = 126000,
  parameter int SETTLE_CYC      = 126000,
  parameter int XCLK_DIV        = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       restart,
  output logic       cam_xclk,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_start,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_AB  = (LOCK_STABLE_CYC > PWDN_CYC) ? LOCK_STABLE_CYC : PWDN_CYC;
  localparam int MAX_CD  = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int HALF    = XCLK_DIV / 2;
  localparam int DIV_W   = $clog2(HALF + 1);

  localparam logic [CNT_W-1:0] LOCK_M1   = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] PWDN_M1   = CNT_W'(PWDN_CYC - 1);
  localparam logic [CNT_W-1:0] RST_M1    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);
  localparam logic [DIV_W-1:0] HALF_M1   = DIV_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_XCLK_ON,
    S_PWDN_LOW,
    S_RST_REL,
    S_READY
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q;
  logic             abort;
  logic             lost_d;
  logic             run_d;
  logic             pwdn_d;
  logic             crst_d;
  logic             ready_d;
  logic             cfg_d;

  // Shared counter counts lock-high cycles in WAIT_LOCK and counts down state dwell times elsewhere
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lost_d  = 1'b0;
    abort   = (state_q != S_WAIT_LOCK) && (!lock || restart);
    case (state_q)
      S_WAIT_LOCK: begin
        if (!lock) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_M1) begin
          state_d = S_XCLK_ON;
          cnt_d   = PWDN_M1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XCLK_ON: begin
        if (cnt_q == '0) begin
          state_d = S_PWDN_LOW;
          cnt_d   = RST_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PWDN_LOW: begin
        if (cnt_q == '0) begin
          state_d = S_RST_REL;
          cnt_d   = SETTLE_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RST_REL: begin
        if (cnt_q == '0) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_READY: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Lock loss wins over restart; both abort to WAIT_LOCK, only loss is flagged
    if (abort) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
      lost_d  = !lock;
    end
  end

  assign run_d   = (state_d != S_WAIT_LOCK) && (state_q != S_WAIT_LOCK);
  assign pwdn_d  = (state_d == S_WAIT_LOCK) || (state_d == S_XCLK_ON);
  assign crst_d  = (state_d == S_RST_REL) || (state_d == S_READY);
  assign ready_d = (state_d == S_READY);
  assign cfg_d   = ready_d && (state_q != S_READY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT_LOCK;
      cnt_q     <= '0;
      cam_pwdn  <= 1'b1;
      cam_rst_n <= 1'b0;
      ready     <= 1'b0;
      cfg_start <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cam_pwdn  <= pwdn_d;
      cam_rst_n <= crst_d;
      ready     <= ready_d;
      cfg_start <= cfg_d;
      lock_lost <= lost_d;
    end
  end

  // Divider restarts from zero on each XCLK_ON entry, so the first rising edge lands HALF cycles in
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q    <= '0;
      cam_xclk <= 1'b0;
    end else if (!run_d) begin
      div_q    <= '0;
      cam_xclk <= 1'b0;
    end else if (div_q == HALF_M1) begin
      div_q    <= '0;
      cam_xclk <= ~cam_xclk;
    end else begin
      div_q    <= div_q + 1'b1;
    end
  end

`ifdef CAM_PWR_SEQ_LOSS_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] loss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loss_cnt_q <= 8'd0;
    end else if (lost_d) begin
      loss_cnt_q <= sat_inc8(loss_cnt_q);
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq with short sequencing parameters; expected values hand-derived.
module tb_cam_pwr_seq;

`ifdef CAM_PWR_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       restart;
  logic       cam_xclk;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       cfg_start;
  logic       ready;
  logic       lock_lost;
  logic [7:0] lock_loss_cnt;
  logic [5:0] obs;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [5:0] V_WAIT = 6'b010000;
  localparam logic [5:0] V_LOST = 6'b010001;

  cam_pwr_seq #(
    .LOCK_STABLE_CYC(4),
    .PWDN_CYC(8),
    .RST_CYC(6),
    .SETTLE_CYC(5),
    .XCLK_DIV(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .lock(lock),
    .restart(restart),
    .cam_xclk(cam_xclk),
    .cam_pwdn(cam_pwdn),
    .cam_rst_n(cam_rst_n),
    .cfg_start(cfg_start),
    .ready(ready),
    .lock_lost(lock_lost),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {cam_xclk, cam_pwdn, cam_rst_n, cfg_start, ready, lock_lost};

  // Outputs after the n-th edge counted from a WAIT_LOCK start with lock held high:
  // XCLK_ON at 4, pwdn low at 12, cam_rst_n high at 18, ready+cfg_start at 23, xclk period 4 from 4.
  function automatic logic [5:0] exp_vec(input int n);
    logic x, p, r, c, y;
    x = (n >= 4) && ((((n - 4) / 2) % 2) == 1);
    p = (n < 12);
    r = (n >= 18);
    c = (n == 23);
    y = (n >= 23);
    return {x, p, r, c, y, 1'b0};
  endfunction

  function automatic logic [7:0] exp_cnt(input int v);
    return CNT_EN ? 8'(v) : 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lock = 1'b0; restart = 1'b0;
    tick(); tick();
    vectors++;
    if (obs !== V_WAIT) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected %b", obs, V_WAIT);
    end
    vectors++;
    if (lock_loss_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d expected 0", lock_loss_cnt);
    end
  endtask

  task automatic test_powerup();
    rst_n = 1'b1; lock = 1'b1;
    for (int n = 1; n <= 26; n++) begin
      tick();
      vectors++;
      if (obs !== exp_vec(n)) begin
        miscompares++;
        $display("FAIL powerup_n%0d: got %b expected %b", n, obs, exp_vec(n));
      end
    end
  endtask

  task automatic test_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    vectors++;
    if (obs !== V_WAIT) begin
      miscompares++;
      $display("FAIL restart_exit: got %b expected %b", obs, V_WAIT);
    end
    for (int n = 1; n <= 24; n++) begin
      tick();
      vectors++;
      if (obs !== exp_vec(n)) begin
        miscompares++;
        $display("FAIL restart_seq_n%0d: got %b expected %b", n, obs, exp_vec(n));
      end
    end
    vectors++;
    if (lock_loss_cnt !== exp_cnt(0)) begin
      miscompares++;
      $display("FAIL restart_count: got %0d expected %0d", lock_loss_cnt, exp_cnt(0));
    end
  endtask

  task automatic test_lock_loss();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int n = 1; n <= 13; n++) tick();
    vectors++;
    if (obs !== exp_vec(13)) begin
      miscompares++;
      $display("FAIL loss_in_pwdn_low: got %b expected %b", obs, exp_vec(13));
    end
    lock = 1'b0;
    tick();
    vectors++;
    if (obs !== V_LOST) begin
      miscompares++;
      $display("FAIL loss_pulse: got %b expected %b", obs, V_LOST);
    end
    vectors++;
    if (lock_loss_cnt !== exp_cnt(1)) begin
      miscompares++;
      $display("FAIL loss_count: got %0d expected %0d", lock_loss_cnt, exp_cnt(1));
    end
    lock = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      vectors++;
      if (obs !== exp_vec(n)) begin
        miscompares++;
        $display("FAIL loss_reseq_n%0d: got %b expected %b", n, obs, exp_vec(n));
      end
    end
  endtask

  task automatic test_glitch();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int n = 1; n <= 3; n++) tick();
    lock = 1'b0;
    tick();
    vectors++;
    if (obs !== V_WAIT) begin
      miscompares++;
      $display("FAIL glitch_wait: got %b expected %b", obs, V_WAIT);
    end
    lock = 1'b1;
    // A restart inside WAIT_LOCK must not disturb the lock-stable count
    for (int n = 1; n <= 24; n++) begin
      restart = (n == 2);
      tick();
      vectors++;
      if (obs !== exp_vec(n)) begin
        miscompares++;
        $display("FAIL glitch_seq_n%0d: got %b expected %b", n, obs, exp_vec(n));
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_simultaneous();
    lock = 1'b0; restart = 1'b1;
    tick();
    restart = 1'b0;
    vectors++;
    if (obs !== V_LOST) begin
      miscompares++;
      $display("FAIL simul_pulse: got %b expected %b", obs, V_LOST);
    end
    vectors++;
    if (lock_loss_cnt !== exp_cnt(2)) begin
      miscompares++;
      $display("FAIL simul_count: got %0d expected %0d", lock_loss_cnt, exp_cnt(2));
    end
    tick();
    vectors++;
    if (obs !== V_WAIT) begin
      miscompares++;
      $display("FAIL simul_single_pulse: got %b expected %b", obs, V_WAIT);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      lock = 1'b1;
      repeat (4) tick();
      lock = 1'b0;
      tick();
      if (i == 99) begin
        vectors++;
        if (lock_loss_cnt !== exp_cnt(102)) begin
          miscompares++;
          $display("FAIL sat_mid_count: got %0d expected %0d", lock_loss_cnt, exp_cnt(102));
        end
      end
    end
    vectors++;
    if (obs !== V_LOST) begin
      miscompares++;
      $display("FAIL sat_last_pulse: got %b expected %b", obs, V_LOST);
    end
    vectors++;
    if (lock_loss_cnt !== exp_cnt(255)) begin
      miscompares++;
      $display("FAIL sat_final_count: got %0d expected %0d", lock_loss_cnt, exp_cnt(255));
    end
  endtask

  task automatic test_reset_in_ready();
    lock = 1'b1;
    for (int n = 1; n <= 23; n++) tick();
    vectors++;
    if (obs !== exp_vec(23)) begin
      miscompares++;
      $display("FAIL rr_ready: got %b expected %b", obs, exp_vec(23));
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if (obs !== V_WAIT) begin
      miscompares++;
      $display("FAIL rr_outputs: got %b expected %b", obs, V_WAIT);
    end
    vectors++;
    if (lock_loss_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL rr_count: got %0d expected 0", lock_loss_cnt);
    end
    tick();
    vectors++;
    if (obs !== exp_vec(1)) begin
      miscompares++;
      $display("FAIL rr_after: got %b expected %b", obs, exp_vec(1));
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_restart();
    test_lock_loss();
    test_glitch();
    test_simultaneous();
    test_saturate();
    test_reset_in_ready();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
